// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs raw fields per format into a 4-entry output FIFO.
// Optional immediate range/alignment rejection enabled by defining ENC_RANGE_CHECK_EN.
module inst_encoder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        err,
  input  logic        err_clr,
  output logic [2:0]  count
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0] mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  cnt;
  logic [31:0] enc;
  logic        fmt_ok;
  logic        range_bad;
  logic        accept, reject, push, pop;

  always_comb begin
    enc    = '0;
    fmt_ok = 1'b1;
    case (fmt_e'(in_fmt))
      FMT_R: enc = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      FMT_I: enc = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
      FMT_S: enc = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
      FMT_B: enc = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
      FMT_U: enc = {in_imm[31:12], in_rd, in_opcode};
      FMT_J: enc = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
      default: fmt_ok = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = $signed(in_imm);

  always_comb begin
    range_bad = 1'b0;
    case (fmt_e'(in_fmt))
      FMT_I, FMT_S: range_bad = (imm_s < -2048) || (imm_s > 2047);
      FMT_B:        range_bad = (imm_s < -4096) || (imm_s > 4094) || in_imm[0];
      FMT_J:        range_bad = (imm_s < -1048576) || (imm_s > 1048574) || in_imm[0];
      FMT_U:        range_bad = (in_imm[11:0] != 12'd0);
      default:      range_bad = 1'b0;
    endcase
  end
`else
  assign range_bad = 1'b0;
`endif

  // Full FIFO stalls input even if a pop happens this cycle: no pass-through.
  assign in_ready  = ~cnt[2];
  assign accept    = in_valid & in_ready;
  assign reject    = accept & (~fmt_ok | range_bad);
  assign push      = accept & ~reject;
  assign pop       = out_valid & out_ready;
  assign out_valid = (cnt != 3'd0);
  assign out_inst  = mem[rd_ptr];
  assign count     = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 4; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      err    <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   cnt <= cnt + 3'd1;
        2'b01:   cnt <= cnt - 3'd1;
        default: cnt <= cnt;
      endcase
      if (reject)       err <= 1'b1;
      else if (err_clr) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Self-checking bench for inst_encoder: table of encode vectors plus FIFO, reject and reset sequences.
module tb_inst_encoder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        err;
  logic        err_clr;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .err(err), .err_clr(err_clr), .count(count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [31:0] imm);
    in_valid  = 1'b1;
    in_fmt    = fmt;
    in_opcode = op;
    in_funct3 = f3;
    in_funct7 = f7;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  initial begin
    vecs[0] = '{3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5,          32'h00500093};
    vecs[1] = '{3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3};
    vecs[2] = '{3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423};
    vecs[3] = '{3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC,   32'hFE208EE3};
    vecs[4] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8,          32'h008000EF};
    vecs[5] = '{3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7};
    vecs[6] = '{3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFFFFFFE,   32'hFFFFF06F};
    // unused fields (rs2/f7 for I, imm for R) carry garbage and must not leak
    vecs[7] = '{3'd1, 7'h13, 3'd0, 7'h7F, 5'd2, 5'd3, 5'd31, 32'hFFFFFFFF,  32'hFFF18113};
    vecs[8] = '{3'd0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 32'hFFFFFFFF,   32'h403100B3};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    step; step;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    rst_n = 1'b1;
    step;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].fmt, vecs[i].op, vecs[i].f3, vecs[i].f7,
            vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      check($sformatf("vec%0d_pre_valid", i), {31'd0, out_valid}, 32'd0);
      step;
      in_valid = 1'b0;
      check($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
      check($sformatf("vec%0d_inst", i), out_inst, vecs[i].exp);
      out_ready = 1'b1;
      step;
      out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), {29'd0, count}, 32'd0);
    end

    // Fill: 5 requests with out_ready low; the 5th must be held off.
    for (int i = 0; i < 5; i++) begin
      drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'(i + 1));
      check($sformatf("fill%0d_in_ready", i), {31'd0, in_ready}, (i < 4) ? 32'd1 : 32'd0);
      step;
      check($sformatf("fill%0d_count", i), {29'd0, count}, (i < 4) ? 32'(i + 1) : 32'd4);
      check($sformatf("fill%0d_head", i), out_inst, 32'h00100093);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d_inst", i), out_inst, {12'(i + 1), 20'h00093});
      check($sformatf("drain%0d_count", i), {29'd0, count}, 32'(4 - i));
      step;
    end
    out_ready = 1'b0;
    check("drain_empty", {29'd0, count}, 32'd0);
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Simultaneous push and pop keeps occupancy.
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd7);
    step;
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd9);
    out_ready = 1'b1;
    step;
    in_valid = 1'b0;
    out_ready = 1'b0;
    check("pushpop_count", {29'd0, count}, 32'd1);
    check("pushpop_head", out_inst, 32'h00900093);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;

    // Invalid format: consumed, not queued, sticky err.
    drive(3'd6, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    check("rej_in_ready", {31'd0, in_ready}, 32'd1);
    step;
    in_valid = 1'b0;
    check("rej_count", {29'd0, count}, 32'd0);
    check("rej_err", {31'd0, err}, 32'd1);
    step;
    check("rej_err_sticky", {31'd0, err}, 32'd1);
    drive(3'd7, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd1);
    err_clr = 1'b1;
    step;
    in_valid = 1'b0;
    check("rej_clr_coincident", {31'd0, err}, 32'd1);
    step;
    err_clr = 1'b0;
    check("rej_clr", {31'd0, err}, 32'd0);

    // Out-of-range I immediate.
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048);
    step;
    in_valid = 1'b0;
`ifdef ENC_RANGE_CHECK_EN
    check("range_valid", {31'd0, out_valid}, 32'd0);
    check("range_err", {31'd0, err}, 32'd1);
    err_clr = 1'b1;
    step;
    err_clr = 1'b0;
    check("range_err_clr", {31'd0, err}, 32'd0);
`else
    check("range_valid", {31'd0, out_valid}, 32'd1);
    check("range_inst", out_inst, 32'h80000093);
    check("range_err", {31'd0, err}, 32'd0);
    out_ready = 1'b1;
    step;
    out_ready = 1'b0;
`endif

    // Asynchronous reset with three queued words.
    for (int i = 0; i < 3; i++) begin
      drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'(i + 20));
      step;
    end
    in_valid = 1'b0;
    check("arst_pre_count", {29'd0, count}, 32'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_count", {29'd0, count}, 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_inst", out_inst, 32'd0);
    step;
    rst_n = 1'b1;
    step;
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_no_stale", {31'd0, out_valid}, 32'd0);
    drive(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5);
    step;
    in_valid = 1'b0;
    check("arst_fresh", out_inst, 32'h00500093);
    check("arst_fresh_count", {29'd0, count}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock, sole clock.
REQ-002 SHALL have port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL have port: in_valid  input  1  encode request valid.
REQ-004 SHALL have port: in_ready  output  1  request accepted when in_valid&in_ready at clk edge.
REQ-005 SHALL have port: in_fmt  input  3  format; 0=R 1=I 2=S 3=B 4=U 5=J, 6-7 invalid.
REQ-006 SHALL have ports: in_opcode  input  7; in_funct3  input  3; in_funct7  input  7  raw field values.
REQ-007 SHALL have ports: in_rd, in_rs1, in_rs2  input  5 each  register numbers.
REQ-008 SHALL have port: in_imm  input  32  signed byte-offset/immediate, unencoded.
REQ-009 SHALL have ports: out_valid  output  1; out_ready  input  1; out_inst  output  32  encoded RV32I word.
REQ-010 SHALL have ports: err  output  1  sticky reject flag; err_clr  input  1  synchronous clear; count  output  3  FIFO occupancy 0-4.

Function
REQ-011 SHALL encode: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}.
REQ-012 SHALL encode: B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-013 SHALL ignore fields unused by the selected format.
REQ-014 SHALL hold encoded words in a 4-entry FIFO; out_inst/out_valid reflect the head entry.
REQ-015 SHALL assert in_ready iff count<4, independent of out_ready (no same-cycle pass-through when full).
REQ-016 SHALL write an accepted, non-rejected word at the accepting edge; out_valid earliest one cycle later (latency 1).
REQ-017 SHALL pop head on out_valid&out_ready; simultaneous push and pop leaves count unchanged.
REQ-018 SHALL hold out_inst stable while out_valid&!out_ready.
REQ-019 SHALL wrap read/write pointers modulo 4.
REQ-020 SHALL reject (not enqueue) an accepted request with in_fmt 6 or 7, and set err at that edge.
REQ-021 SHALL keep err set until err_clr or reset; err_clr coincident with a new reject leaves err=1.
REQ-022 SHALL still assert in_ready for rejected requests (reject consumes the request).

Reset
REQ-023 SHALL on rst_n low asynchronously force: count=0, out_valid=0, out_inst=0, err=0, pointers=0.
REQ-024 SHALL discard all FIFO contents on reset mid-operation; in_ready=1 from first edge after rst_n high.

Configuration
REQ-025 SHALL, with ENC_RANGE_CHECK_EN defined, reject with err: I/S imm outside [-2048,2047]; B imm outside [-4096,4094] or odd; J imm outside [-1048576,1048574] or odd; U imm[11:0]!=0.
REQ-026 SHALL, without ENC_RANGE_CHECK_EN, perform no range/alignment checks and silently truncate imm bits per REQ-011/012; only invalid in_fmt rejects.

Verification
REQ-027 SHALL cover: fmt=I op=0x13 f3=0 rd=1 rs1=0 imm=5 -> out_inst=0x00500093 one cycle later.
REQ-028 SHALL cover: fmt=R op=0x33 f3=0 f7=0 rd=3 rs1=1 rs2=2 -> 0x002081B3; fmt=S op=0x23 f3=2 rs1=1 rs2=2 imm=8 -> 0x0020A423.
REQ-029 SHALL cover: fmt=B op=0x63 f3=0 rs1=1 rs2=2 imm=-4 -> 0xFE208EE3; fmt=J op=0x6F rd=1 imm=8 -> 0x008000EF.
REQ-030 SHALL cover: 5 back-to-back requests with out_ready=0 -> in_ready=0 after 4th, count=4; then out_ready=1 -> words drain in order, count 4->0.
REQ-031 SHALL cover: with ENC_RANGE_CHECK_EN, fmt=I imm=2048 -> no output, err=1; err_clr -> err=0; without macro same stimulus -> out_inst imm field 0x800, err=0.
REQ-032 SHALL cover: rst_n low with count=3 -> count=0, out_valid=0 immediately, no stale word after release.
